// File: rtl/i2s_rx.sv
// I2S receiver: synchronizes sck/ws/sd into the clk domain, assembles
// MSB-first words with the standard one-bit ws delay, and presents
// per-channel words with one-clk valid pulses and a sticky length-error flag.
module i2s_rx #(
  parameter int unsigned AUDIO_DW    = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                i2s_sck,
  input  logic                i2s_ws,
  input  logic                i2s_sd,
  input  logic                err_clr,
  output logic [AUDIO_DW-1:0] l_data,
  output logic [AUDIO_DW-1:0] r_data,
  output logic                l_valid,
  output logic                r_valid,
  output logic                len_err
);

  localparam int unsigned CNT_W = $clog2(AUDIO_DW + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(AUDIO_DW);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(AUDIO_DW + 1);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    RUN
  } state_t;

  // synchronizer chains, bit 0 is the first stage
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] ws_sync_q,  ws_sync_d;
  logic [SYNC_STAGES-1:0] sd_sync_q,  sd_sync_d;

  logic sck_s, ws_s, sd_s;
  logic sck_prev_q, sck_prev_d;
  logic rise_q, rise_d;
  logic boundary;

  // word assembly
  logic [AUDIO_DW-1:0] shift_q, shift_d;
  logic                ws_q, ws_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  state_t              state_q, state_d;

  // completed-word decision, applied to the outputs one clk later
  logic pend_l_q, pend_l_d;
  logic pend_r_q, pend_r_d;
  logic pend_err_q, pend_err_d;

  // registered outputs
  logic [AUDIO_DW-1:0] l_data_q, l_data_d;
  logic [AUDIO_DW-1:0] r_data_q, r_data_d;
  logic                l_valid_q, l_valid_d;
  logic                r_valid_q, r_valid_d;
  logic                len_err_q, len_err_d;

  assign sck_s = sck_sync_q[SYNC_STAGES-1];
  assign ws_s  = ws_sync_q[SYNC_STAGES-1];
  assign sd_s  = sd_sync_q[SYNC_STAGES-1];

  // a word ends on the sck rise where ws changes; that rise carries the LSB
  assign boundary = rise_q && (ws_s != ws_q);

  // next-state logic for synchronizers, word assembly, FSM and outputs
  always_comb begin
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], i2s_sck};
    ws_sync_d  = {ws_sync_q[SYNC_STAGES-2:0], i2s_ws};
    sd_sync_d  = {sd_sync_q[SYNC_STAGES-2:0], i2s_sd};

    sck_prev_d = sck_s;
    rise_d     = sck_s && !sck_prev_q;

    shift_d    = shift_q;
    ws_d       = ws_q;
    bit_cnt_d  = bit_cnt_q;
    state_d    = state_q;
    pend_l_d   = 1'b0;
    pend_r_d   = 1'b0;
    pend_err_d = 1'b0;
    l_data_d   = l_data_q;
    r_data_d   = r_data_q;
    l_valid_d  = 1'b0;
    r_valid_d  = 1'b0;

    // Datapath keeps tracking ws even while disabled, so the first boundary
    // seen after re-enable is a genuine word edge rather than a stale compare.
    if (rise_q) begin
      shift_d = {shift_q[AUDIO_DW-2:0], sd_s};
      ws_d    = ws_s;
      if (boundary) begin
        bit_cnt_d = CNT_W'(1);
      end else if (bit_cnt_q < CNT_SAT) begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end

    if (!en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = SYNC;
        SYNC: if (boundary) state_d = RUN;
        RUN: begin
          if (boundary) begin
            if (bit_cnt_q == CNT_FULL) begin
              pend_l_d = !ws_q;
              pend_r_d = ws_q;
            end else begin
              pend_err_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (pend_l_q) begin
      l_data_d  = shift_q;
      l_valid_d = 1'b1;
    end
    if (pend_r_q) begin
      r_data_d  = shift_q;
      r_valid_d = 1'b1;
    end

    // a new error in the same cycle as err_clr leaves the flag set
    if (pend_err_q) begin
      len_err_d = 1'b1;
    end else if (err_clr) begin
      len_err_d = 1'b0;
    end else begin
      len_err_d = len_err_q;
    end
  end

  // all state, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q <= '0;
      ws_sync_q  <= '0;
      sd_sync_q  <= '0;
      sck_prev_q <= 1'b0;
      rise_q     <= 1'b0;
      shift_q    <= '0;
      ws_q       <= 1'b0;
      bit_cnt_q  <= '0;
      state_q    <= IDLE;
      pend_l_q   <= 1'b0;
      pend_r_q   <= 1'b0;
      pend_err_q <= 1'b0;
      l_data_q   <= '0;
      r_data_q   <= '0;
      l_valid_q  <= 1'b0;
      r_valid_q  <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      sck_sync_q <= sck_sync_d;
      ws_sync_q  <= ws_sync_d;
      sd_sync_q  <= sd_sync_d;
      sck_prev_q <= sck_prev_d;
      rise_q     <= rise_d;
      shift_q    <= shift_d;
      ws_q       <= ws_d;
      bit_cnt_q  <= bit_cnt_d;
      state_q    <= state_d;
      pend_l_q   <= pend_l_d;
      pend_r_q   <= pend_r_d;
      pend_err_q <= pend_err_d;
      l_data_q   <= l_data_d;
      r_data_q   <= r_data_d;
      l_valid_q  <= l_valid_d;
      r_valid_q  <= r_valid_d;
      len_err_q  <= len_err_d;
    end
  end

  assign l_data  = l_data_q;
  assign r_data  = r_data_q;
  assign l_valid = l_valid_q;
  assign r_valid = r_valid_q;
  assign len_err = len_err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives a word-level I2S stream and compares every valid,
// data word, latency and the error flag against a word-level model.
module tb_i2s_rx;

  localparam int DW   = 8;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          i2s_sck = 1'b0;
  logic          i2s_ws = 1'b0;
  logic          i2s_sd = 1'b0;
  logic          err_clr;
  logic [DW-1:0] l_data, r_data;
  logic          l_valid, r_valid, len_err;

  i2s_rx #(.AUDIO_DW(DW), .SYNC_STAGES(SYNC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .i2s_sck (i2s_sck),
    .i2s_ws  (i2s_ws),
    .i2s_sd  (i2s_sd),
    .err_clr (err_clr),
    .l_data  (l_data),
    .r_data  (r_data),
    .l_valid (l_valid),
    .r_valid (r_valid),
    .len_err (len_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // word-level reference model state
  typedef struct {
    bit            ch;
    logic [DW-1:0] val;
    int            due;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] exp_l = '0;
  logic [DW-1:0] exp_r = '0;
  logic          exp_err = 1'b0;
  bit            synced = 1'b0;
  bit            cur_ch = 1'b0;
  int            ratio = 8;
  int            clr_due = -100;
  logic          manual_clr = 1'b0;
  logic          clr_hit = 1'b0;

  assign err_clr = manual_clr | clr_hit;

  // err_clr pulse timed to land on the cycle a predicted error is set
  always @(negedge clk) clr_hit <= (cyc == clr_due - 1);

  // output monitor: every valid must match the next expected word
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (l_valid || r_valid)) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_valid", 32'({l_valid, r_valid}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("valid_ch", 32'({l_valid, r_valid}), e.ch ? 32'd1 : 32'd2);
          check_eq("word_data", 32'(e.ch ? r_data : l_data), 32'(e.val));
          check_eq("latency", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  // one bit period: ws/sd change with sck low, receiver samples on the rise
  task automatic drive_slot(input bit ws, input bit sd, output int rise_cyc);
    @(negedge clk);
    i2s_sck = 1'b0;
    i2s_ws  = ws;
    i2s_sd  = sd;
    repeat (ratio / 2 - 1) @(negedge clk);
    @(negedge clk);
    i2s_sck  = 1'b1;
    rise_cyc = cyc + 1;
    repeat (ratio / 2 - 1) @(negedge clk);
  endtask

  // model: a word completes on its LSB rise; delivered only if the receiver
  // had already seen a boundary since enable and the length is right
  task automatic model_boundary(input logic [15:0] val, input int len, input int rc, input bit clr_same);
    if (en && synced) begin
      if (len == DW) begin
        exp_q.push_back('{cur_ch, val[DW-1:0], rc + LAT});
        if (cur_ch) exp_r = val[DW-1:0];
        else        exp_l = val[DW-1:0];
      end else begin
        exp_err = 1'b1;
        if (clr_same) clr_due = rc + LAT;
      end
    end
    if (en) synced = 1'b1;
  endtask

  task automatic send_word(input logic [15:0] val, input int len, input int en_slot,
                           input bit en_val, input bit clr_same);
    int rc;
    bit ws;
    for (int i = 0; i < len; i++) begin
      if (i == en_slot) begin
        en = en_val;
        if (!en_val) synced = 1'b0;
      end
      ws = (i == len - 1) ? !cur_ch : cur_ch;
      drive_slot(ws, val[len-1-i], rc);
      if (i == len - 1) model_boundary(val, len, rc, clr_same);
    end
    cur_ch = !cur_ch;
  endtask

  task automatic settle_and_check(input string phase);
    repeat (2 * ratio + 8) @(negedge clk);
    check_eq({phase, "_pending"}, 32'(exp_q.size()), 32'd0);
    check_eq({phase, "_l_data"}, 32'(l_data), 32'(exp_l));
    check_eq({phase, "_r_data"}, 32'(r_data), 32'(exp_r));
    check_eq({phase, "_len_err"}, 32'(len_err), 32'(exp_err));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_l_data"}, 32'(l_data), 32'd0);
    check_eq({tag, "_r_data"}, 32'(r_data), 32'd0);
    check_eq({tag, "_valids"}, 32'({l_valid, r_valid}), 32'd0);
    check_eq({tag, "_len_err"}, 32'(len_err), 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int bit_idx;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;

    // repeated L/R pattern at 8:1, first word discarded
    ratio = 8;
    for (int f = 0; f < 3; f++) begin
      send_word(16'h00A5, 8, -1, 1'b0, 1'b0);
      send_word(16'h003C, 8, -1, 1'b0, 1'b0);
    end
    settle_and_check("pattern");

    // random words at 6:1
    ratio = 6;
    for (int w = 0; w < 8; w++) send_word(16'($urandom_range(0, 255)), 8, -1, 1'b0, 1'b0);
    settle_and_check("random");

    // short left word, then a good right word
    ratio = 8;
    send_word(16'h0055, 7, -1, 1'b0, 1'b0);
    send_word(16'h0081, 8, -1, 1'b0, 1'b0);
    settle_and_check("short");

    // err_clr alone clears the flag
    manual_clr = 1'b1;
    @(negedge clk);
    manual_clr = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    check_eq("clr_alone", 32'(len_err), 32'(exp_err));

    // long word with err_clr in the same cycle as the error
    send_word(16'($urandom_range(0, 255)), 8, -1, 1'b0, 1'b0);
    send_word(16'h01F3, 9, -1, 1'b0, 1'b1);
    settle_and_check("long_clr");
    manual_clr = 1'b1;
    @(negedge clk);
    manual_clr = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    check_eq("clr_after_long", 32'(len_err), 32'(exp_err));

    // drop en for one word, re-raise mid-word
    send_word(16'($urandom_range(0, 255)), 8, -1, 1'b0, 1'b0);
    send_word(16'($urandom_range(0, 255)), 8, -1, 1'b0, 1'b0);
    send_word(16'($urandom_range(0, 255)), 8, 3, 1'b0, 1'b0);
    send_word(16'($urandom_range(0, 255)), 8, 3, 1'b1, 1'b0);
    send_word(16'($urandom_range(0, 255)), 8, -1, 1'b0, 1'b0);
    send_word(16'($urandom_range(0, 255)), 8, -1, 1'b0, 1'b0);
    settle_and_check("en_drop");

    // reset in the middle of a word
    send_word(16'h00A5, 8, -1, 1'b0, 1'b0);
    send_word(16'h003C, 8, -1, 1'b0, 1'b0);
    settle_and_check("pre_reset");
    for (int i = 0; i < 3; i++) drive_slot(1'b0, 1'b1, bit_idx);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    exp_q.delete();
    exp_l   = '0;
    exp_r   = '0;
    exp_err = 1'b0;
    synced  = 1'b0;
    cur_ch  = 1'b0;
    i2s_sck = 1'b0;
    i2s_ws  = 1'b0;
    i2s_sd  = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("held_reset");
    rst_n = 1'b1;
    for (int f = 0; f < 2; f++) begin
      send_word(16'h00A5, 8, -1, 1'b0, 1'b0);
      send_word(16'h003C, 8, -1, 1'b0, 1'b0);
    end
    settle_and_check("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter AUDIO_DW, default 8: sample word width in bits per channel.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth for sck/ws/sd; legal range 2..3.
REQ-003 clk  input  1  system clock; the only clock of the block.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 en  input  1  receive enable; 0 holds the word-assembly state machine in IDLE.
REQ-006 i2s_sck  input  1  serial bit clock, asynchronous to clk.
REQ-007 i2s_ws  input  1  word select; 0 = left channel, 1 = right channel.
REQ-008 i2s_sd  input  1  serial data, MSB first.
REQ-009 l_data  output  AUDIO_DW  last complete left-channel word.
REQ-010 r_data  output  AUDIO_DW  last complete right-channel word.
REQ-011 l_valid  output  1  one-clk pulse when l_data updates.
REQ-012 r_valid  output  1  one-clk pulse when r_data updates.
REQ-013 len_err  output  1  sticky flag: a word of the wrong length was received.
REQ-014 err_clr  input  1  synchronous clear of len_err.

Function
REQ-015 i2s_sck, i2s_ws and i2s_sd SHALL each pass through SYNC_STAGES flops on clk before any use.
REQ-016 clk frequency SHALL be at least 6x i2s_sck frequency; the block is not required to operate below that ratio.
REQ-017 An sck rise event SHALL be detected as synchronized sck = 1 with its previous-cycle value = 0, and SHALL last exactly one clk.
REQ-018 On each sck rise event, the block SHALL shift synchronized sd into a shift register (shift_reg <= {shift_reg[AUDIO_DW-2:0], sd}) and SHALL store synchronized ws into ws_q.
REQ-019 Word boundary: on an sck rise where sampled ws differs from ws_q, the bit shifted in that cycle SHALL be the LSB of the completed word. This is the standard one-bit I2S delay.
REQ-020 State machine states: IDLE, SYNC, RUN.
- IDLE -> SYNC when en = 1.
- SYNC -> RUN on the first word boundary; no word is output from SYNC.
- any state -> IDLE when en = 0.
REQ-021 bit_cnt SHALL be cleared to 1 at every word boundary and incremented on every other sck rise event, saturating at AUDIO_DW+1.
REQ-022 At a word boundary in RUN, when bit_cnt (including the boundary bit) equals AUDIO_DW, the block SHALL:
- load the new shift_reg value into l_data if the previous ws_q = 0, or into r_data if it = 1;
- pulse the matching valid one clk after the boundary sck rise event.
REQ-023 At a word boundary in RUN, when bit_cnt differs from AUDIO_DW (short word, or saturated long word), the block SHALL set len_err, SHALL leave both data outputs unchanged, and SHALL NOT pulse either valid.
REQ-024 When err_clr and a new error occur in the same cycle, len_err SHALL be 1 (set wins).
REQ-025 Both data outputs SHALL hold their value between updates; the valids SHALL be mutually exclusive.
REQ-026 When en goes low in the middle of a word, the partial word SHALL be discarded. On re-enable, the block SHALL resynchronize through SYNC.
REQ-027 Latency from the sck rise that carries the LSB to the valid pulse SHALL be SYNC_STAGES+2 clk cycles.

Reset
REQ-028 While rst_n = 0, the following SHALL be 0: l_data, r_data, l_valid, r_valid, len_err, shift_reg, bit_cnt, ws_q and all synchronizer flops; the state SHALL be IDLE.
REQ-029 Release of rst_n is the integrator's responsibility to synchronize to clk. After release, the block SHALL require one full word boundary (SYNC) before the first valid.

Verification
REQ-030 Reset, en = 1, 8-bit I2S stream with L = 0xA5, R = 0x3C repeated -> first word discarded; thereafter l_data = 0xA5 with l_valid, r_data = 0x3C with r_valid, alternating; len_err = 0.
REQ-031 Latency check -> valid asserts exactly SYNC_STAGES+2 clk after the LSB sck rise, measured at clk:sck = 8:1 and again at 6:1.
REQ-032 Inject a 7-bit left word of 0x55 -> len_err = 1, l_data keeps its previous value, no l_valid; the next good R = 0x81 still updates r_data.
REQ-033 Assert err_clr and inject a 9-bit word in the same cycle -> len_err stays 1; err_clr alone -> len_err = 0.
REQ-034 Drop en for one word mid-stream, then re-raise it -> no valids while disabled; after re-raise, first boundary produces no output; the following word is delivered correctly.
REQ-035 Assert rst_n low mid-word -> all outputs 0 immediately, asynchronously with respect to clk; after release, behaviour matches REQ-030.
